mem_responder: RTL and testbench

- System-side responder for the CPU's memory interface: decodes `mem_rd`/`mem_wr` with the address on `a_bus` and write data on `b_bus`, and returns read data on `result_bus`.
- Contains a word-addressed RAM and a memory-mapped down-counting timer whose interrupt drives the CPU's `hwint` input.
- Instantiated beside `cpu` at system top level; the only bus responder.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mmio_timer.sv | 96 +++++++++
 rtl/mem_responder.sv | 66 ++++++
 tb/tb_mem_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the CPU memory-interface responder.
// Covers the RAM size, the timer MMIO window and the timer register layout.
package mem_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned RAM_WORDS_DEF = 4096;
    localparam int unsigned MMIO_REGS     = 4;
    localparam logic [DATA_W-1:0] MMIO_BASE_DEF = 32'hFFFF_FF00;

    // Bit 0 is EN, bit 1 AUTO (auto-reload), bit 2 IE
    typedef struct packed {
        logic ie;
        logic auto_rld;
        logic en;
    } timer_ctrl_t;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_LOAD   = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } mmio_reg_e;

endpackage

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer: CTRL/LOAD/COUNT/STATUS registers,
// expiry with optional auto-reload, and a level interrupt.
module mmio_timer
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [1:0]        wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        rd_sel,
    output logic [DATA_W-1:0] rd_data,
    output logic              irq
);

    timer_ctrl_t       ctrl_q, ctrl_d;
    logic [DATA_W-1:0] load_q, load_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic              pending_q, pending_d;

    mmio_reg_e wr_reg;
    mmio_reg_e rd_reg;
    logic      wr_ctrl;
    logic      wr_load;
    logic      clr_status;

    always_comb begin
        wr_reg     = mmio_reg_e'(wr_sel);
        rd_reg     = mmio_reg_e'(rd_sel);
        wr_ctrl    = wr_en && (wr_reg == REG_CTRL);
        wr_load    = wr_en && (wr_reg == REG_LOAD);
        clr_status = wr_en && (wr_reg == REG_STATUS) && wr_data[0];
    end

    // Order matters: status clear, then tick (set wins), then register writes win
    always_comb begin
        ctrl_d    = ctrl_q;
        load_d    = load_q;
        count_d   = count_q;
        pending_d = pending_q;

        if (clr_status) begin
            pending_d = 1'b0;
        end

        if (ctrl_q.en && !wr_load) begin
            if (count_q != '0) begin
                count_d = count_q - DATA_W'(1);
            end else begin
                pending_d = 1'b1;
                if (ctrl_q.auto_rld) begin
                    count_d = load_q;
                end else begin
                    ctrl_d.en = 1'b0;
                end
            end
        end

        if (wr_load) begin
            load_d  = wr_data;
            count_d = wr_data;
        end

        if (wr_ctrl) begin
            ctrl_d = timer_ctrl_t'(wr_data[2:0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q    <= '0;
            load_q    <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_reg)
            REG_CTRL:   rd_data = DATA_W'(ctrl_q);
            REG_LOAD:   rd_data = load_q;
            REG_COUNT:  rd_data = count_q;
            REG_STATUS: rd_data = DATA_W'(pending_q);
            default:    rd_data = '0;
        endcase
    end

    assign irq = pending_q & ctrl_q.ie;

endmodule

// File: rtl/mem_responder.sv
// Sole responder on the CPU memory bus: word RAM, timer MMIO window, and a
// zero-latency tri-state read path onto result_bus.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned       RAM_WORDS = RAM_WORDS_DEF,
    parameter logic [DATA_W-1:0] MMIO_BASE = MMIO_BASE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_bus,
    input  logic [DATA_W-1:0] b_bus,
    inout  tri   [DATA_W-1:0] result_bus,
    input  logic              mem_rd,
    input  logic              mem_wr,
    output logic              hwint
);

    localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    logic [DATA_W-1:0] ram_q [RAM_WORDS];

    logic [DATA_W-1:0] mmio_off;
    logic              ram_sel;
    logic              mmio_sel;
    logic [RAM_AW-1:0] ram_idx;
    logic [DATA_W-1:0] tmr_rd;
    logic [DATA_W-1:0] rd_word;
    logic              tmr_wr;

    // Unsigned offset compare also rejects addresses below MMIO_BASE
    always_comb begin
        mmio_off = a_bus - MMIO_BASE;
        ram_sel  = a_bus < DATA_W'(RAM_WORDS);
        mmio_sel = mmio_off < DATA_W'(MMIO_REGS);
        ram_idx  = a_bus[RAM_AW-1:0];
        tmr_wr   = mem_wr && mmio_sel;
        rd_word  = '0;
        if (ram_sel) begin
            rd_word = ram_q[ram_idx];
        end else if (mmio_sel) begin
            rd_word = tmr_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr && ram_sel) begin
            ram_q[ram_idx] <= b_bus;
        end
    end

    // Read value is pre-edge state, so a simultaneous write returns the old word
    assign result_bus = (mem_rd && !rst) ? rd_word : 'z;

    mmio_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tmr_wr),
        .wr_sel  (mmio_off[1:0]),
        .wr_data (b_bus),
        .rd_sel  (mmio_off[1:0]),
        .rd_data (tmr_rd),
        .irq     (hwint)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized bench for mem_responder against a behavioural model
// of the RAM and timer built from the bus-level rules.
module tb_mem_responder;

    localparam logic [31:0] MMIO = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_bus;
    logic [31:0] b_bus;
    wire  [31:0] result_bus;
    logic        mem_rd;
    logic        mem_wr;
    logic        hwint;

    mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .a_bus      (a_bus),
        .b_bus      (b_bus),
        .result_bus (result_bus),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .hwint      (hwint)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rd;
    logic        last_hw;

    // Reference model state
    logic [31:0] m_ram [4096];
    logic        m_en, m_auto, m_ie, m_pend;
    logic [31:0] m_load, m_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_en = 0; m_auto = 0; m_ie = 0; m_pend = 0;
        m_load = 0; m_count = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - MMIO;
        if (addr < 32'd4096) return m_ram[addr[11:0]];
        if (addr >= MMIO && off < 32'd4) begin
            case (off)
                32'd0:   return {29'd0, m_ie, m_auto, m_en};
                32'd1:   return m_load;
                32'd2:   return m_count;
                default: return {31'd0, m_pend};
            endcase
        end
        return 32'd0;
    endfunction

    // One rising edge of the system, given the write strobe seen at that edge
    task automatic m_edge(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        bit load_wr, ctrl_wr, clr, expires, ticks;
        load_wr = wr && addr == MMIO + 32'd1;
        ctrl_wr = wr && addr == MMIO;
        clr     = wr && addr == MMIO + 32'd3 && data[0];
        expires = m_en && m_count == 0 && !load_wr;
        ticks   = m_en && m_count != 0 && !load_wr;
        if (wr && addr < 32'd4096) m_ram[addr[11:0]] = data;
        if (clr && !expires) m_pend = 0;
        if (expires) m_pend = 1;
        if (ticks) m_count = m_count - 1;
        if (expires) begin
            if (m_auto) m_count = m_load;
            else        m_en = 0;
        end
        if (load_wr) begin m_load = data; m_count = data; end
        if (ctrl_wr) {m_ie, m_auto, m_en} = data[2:0];
    endtask

    // Drive one bus cycle, check hwint and any read, then apply the edge to the model
    task automatic cyc(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] exp_rd;
        @(negedge clk);
        mem_rd = rd; mem_wr = wr; a_bus = addr; b_bus = data;
        #1;
        exp_rd  = m_read(addr);
        last_hw = hwint;
        chk("hwint", {31'd0, hwint}, {31'd0, m_pend & m_ie});
        if (rd) begin
            last_rd = result_bus;
            chk("read", result_bus, exp_rd);
        end
        @(posedge clk);
        m_edge(wr, addr, data);
        #1;
        mem_rd = 0; mem_wr = 0;
    endtask

    initial begin
        bit idle_ok;
        logic [31:0] ra;
        rst = 1; mem_rd = 0; mem_wr = 0; a_bus = 0; b_bus = 0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("hwint_reset", {31'd0, hwint}, 32'd0);
        rst = 0;
        @(posedge clk); m_edge(0, 0, 0);

        cyc(1, 0, MMIO + 0, 0); chk("rst_ctrl", last_rd, 32'd0);
        cyc(1, 0, MMIO + 1, 0); chk("rst_load", last_rd, 32'd0);
        cyc(1, 0, MMIO + 2, 0); chk("rst_count", last_rd, 32'd0);
        cyc(1, 0, MMIO + 3, 0); chk("rst_status", last_rd, 32'd0);

        cyc(0, 1, 5, 32'hDEAD_BEEF);
        cyc(1, 0, 5, 0); chk("ram5", last_rd, 32'hDEAD_BEEF);
        cyc(0, 0, 5, 0);
        #1;
        idle_ok = (result_bus === 32'hzzzz_zzzz) || (result_bus === 32'd0);
        chk("bus_idle", {31'd0, idle_ok}, 32'd1);

        cyc(0, 1, 0, 32'h1234_5678);
        cyc(0, 1, 32'h0001_0000, 32'hBAD0_BAD0);
        cyc(1, 0, 32'h0001_0000, 0); chk("unmapped_rd", last_rd, 32'd0);
        cyc(1, 0, 0, 0);             chk("ram0_kept", last_rd, 32'h1234_5678);
        cyc(0, 1, 4095, 32'hCAFE_F00D);
        cyc(1, 0, 4095, 0);     chk("ram_top", last_rd, 32'hCAFE_F00D);
        cyc(1, 0, 4096, 0);     chk("ram_end", last_rd, 32'd0);
        cyc(1, 0, MMIO - 1, 0); chk("below_mmio", last_rd, 32'd0);
        cyc(1, 0, MMIO + 4, 0); chk("above_mmio", last_rd, 32'd0);

        cyc(1, 1, 5, 32'h0BAD_F00D); chk("rdwr_old", last_rd, 32'hDEAD_BEEF);
        cyc(1, 0, 5, 0);             chk("rdwr_new", last_rd, 32'h0BAD_F00D);
        cyc(0, 1, 5, 32'hDEAD_BEEF);

        // One-shot timer
        cyc(0, 1, MMIO + 1, 3);
        cyc(0, 1, MMIO + 0, 32'h5);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, MMIO + 2, 0); chk("oneshot_count", last_rd, 32'(3 - i));
        end
        cyc(1, 0, MMIO + 2, 0); chk("oneshot_hold", last_rd, 32'd0);
        chk("oneshot_irq", {31'd0, last_hw}, 32'd1);
        cyc(1, 0, MMIO + 0, 0); chk("oneshot_en_off", last_rd, 32'h4);
        cyc(1, 0, MMIO + 3, 0); chk("oneshot_pend", last_rd, 32'd1);

        // Auto-reload timer
        cyc(0, 1, MMIO + 0, 0);
        cyc(0, 1, MMIO + 3, 1);
        cyc(0, 1, MMIO + 1, 2);
        cyc(0, 1, MMIO + 0, 32'h7);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, MMIO + 2, 0); chk("auto_count", last_rd, 32'(2 - (i % 3)));
        end
        cyc(0, 0, 0, 0);
        cyc(0, 1, MMIO + 3, 1);
        cyc(1, 0, MMIO + 3, 0); chk("clr_pend", last_rd, 32'd0);
        chk("clr_irq", {31'd0, last_hw}, 32'd0);
        cyc(1, 0, MMIO + 3, 0); chk("auto_pend", last_rd, 32'd1);
        cyc(0, 0, 0, 0);
        cyc(0, 1, MMIO + 3, 1);
        cyc(1, 0, MMIO + 3, 0); chk("set_wins", last_rd, 32'd1);
        chk("set_wins_irq", {31'd0, last_hw}, 32'd1);

        // LOAD write on an expiry edge
        cyc(0, 1, MMIO + 3, 1);
        cyc(0, 1, MMIO + 1, 10);
        cyc(1, 0, MMIO + 2, 0); chk("load_wins", last_rd, 32'd10);
        cyc(1, 0, MMIO + 3, 0); chk("load_no_exp", last_rd, 32'd0);

        // Reset mid-count with COUNT=5 and PENDING=1
        cyc(0, 1, MMIO + 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, MMIO + 0, 32'h4);
        cyc(0, 1, MMIO + 1, 5);
        cyc(0, 1, MMIO + 0, 32'h5);
        @(negedge clk);
        chk("pre_rst_irq", {31'd0, hwint}, 32'd1);
        chk("pre_rst_model", m_count, 32'd5);
        #2 rst = 1;
        m_reset();
        #1 chk("async_rst_irq", {31'd0, hwint}, 32'd0);
        @(posedge clk);
        @(negedge clk) rst = 0;
        @(posedge clk); m_edge(0, 0, 0);
        cyc(1, 0, MMIO + 0, 0); chk("mid_rst_ctrl", last_rd, 32'd0);
        cyc(1, 0, MMIO + 2, 0); chk("mid_rst_count", last_rd, 32'd0);
        cyc(1, 0, MMIO + 3, 0); chk("mid_rst_status", last_rd, 32'd0);
        cyc(1, 0, 5, 0);        chk("ram_survives", last_rd, 32'hDEAD_BEEF);

        // Randomized traffic checked against the model
        for (int i = 0; i < 8; i++) cyc(0, 1, 32'(i), $urandom);
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 10))
                0, 1: cyc(1, 0, 32'($urandom_range(0, 7)), 0);
                2:    cyc(0, 1, 32'($urandom_range(0, 7)), $urandom);
                3:    cyc(1, 0, MMIO + 32'($urandom_range(0, 3)), 0);
                4:    cyc(0, 1, MMIO + 0, $urandom);
                5:    cyc(0, 1, MMIO + 1, 32'($urandom_range(0, 6)));
                6:    cyc(0, 1, MMIO + 3, $urandom);
                7:    cyc(0, 1, MMIO + 2, $urandom);
                8: begin
                    ra = $urandom;
                    if (ra < 32'd4096 || (ra >= MMIO && ra - MMIO < 32'd4)) ra = 32'h0001_0000;
                    cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom);
                end
                9: begin
                    if ($urandom_range(0, 1) == 1) ra = 32'($urandom_range(0, 7));
                    else ra = MMIO + 32'($urandom_range(0, 3));
                    cyc(1, 1, ra, 32'($urandom_range(0, 7)));
                end
                default: cyc(0, 0, 0, 0);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
